// File: rtl/proc_pkg.sv
// Shared types and widths for the 16-bit pipeline stages.
package proc_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: issues variable-latency data-memory requests, stalls upstream while an
// access is outstanding and delivers one registered write-back bundle per instruction.
module mem_stage
  import proc_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [DW-1:0]      aluresult,
  input  logic [INSTR_W-1:0] instrin,
  input  logic               isld1,
  input  logic               isst1,
  input  logic [DW-1:0]      op2_in,
  input  logic               iswb_in,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DW-1:0]      dmem_addr,
  output logic [DW-1:0]      dmem_wdata,
  input  logic [DW-1:0]      dmem_rdata,
  input  logic               dmem_ack,
  output logic               valid_out,
  output logic [DW-1:0]      wbdata,
  output logic [INSTR_W-1:0] instrout,
  output logic               iswb_out,
  output logic               mem_err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  mem_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               valid_out_q, valid_out_d;
  logic [DW-1:0]      wbdata_q, wbdata_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               iswb_q, iswb_d;
  logic               mem_err_q, mem_err_d;

  logic mem_op;
  logic timeout;

  assign mem_op = isld1 | isst1;
  // The current WAIT cycle is the MAX_WAIT-th cycle with the request high.
  assign timeout = (cnt_q == CntW'(MAX_WAIT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_out_d = 1'b0;
    wbdata_d    = wbdata_q;
    instr_d     = instr_q;
    iswb_d      = iswb_q;
    mem_err_d   = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          instr_d = instrin;
          iswb_d  = iswb_in;
          if (mem_op) begin
            stall   = 1'b1;
            addr_d  = aluresult;
            wdata_d = op2_in;
            we_d    = isst1;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            wbdata_d    = aluresult;
            valid_out_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over a coinciding timeout.
        if (dmem_ack) begin
          req_d       = 1'b0;
          valid_out_d = 1'b1;
          wbdata_d    = we_q ? addr_q : dmem_rdata;
          if (we_q) iswb_d = 1'b0;
          state_d     = IDLE;
        end else if (timeout) begin
          req_d       = 1'b0;
          valid_out_d = 1'b1;
          wbdata_d    = '0;
          iswb_d      = 1'b0;
          mem_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_out_q <= 1'b0;
      wbdata_q    <= '0;
      instr_q     <= '0;
      iswb_q      <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      valid_out_q <= valid_out_d;
      wbdata_q    <= wbdata_d;
      instr_q     <= instr_d;
      iswb_q      <= iswb_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign valid_out  = valid_out_q;
  assign wbdata     = wbdata_q;
  assign instrout   = instr_q;
  assign iswb_out   = iswb_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ALU, load, store, timeout and reset scenarios.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] aluresult = '0;
  logic [15:0] instrin = '0;
  logic        isld1 = 1'b0;
  logic        isst1 = 1'b0;
  logic [15:0] op2_in = '0;
  logic        iswb_in = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        valid_out;
  logic [15:0] wbdata;
  logic [15:0] instrout;
  logic        iswb_out;
  logic        mem_err;

  mem_stage #(.DW(16), .MAX_WAIT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .aluresult  (aluresult),
    .instrin    (instrin),
    .isld1      (isld1),
    .isst1      (isst1),
    .op2_in     (op2_in),
    .iswb_in    (iswb_in),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .valid_out  (valid_out),
    .wbdata     (wbdata),
    .instrout   (instrout),
    .iswb_out   (iswb_out),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] wb;
    logic [15:0] instr;
    logic        iswb;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_out", {16'h0, wbdata}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_wbdata", {16'h0, wbdata}, {16'h0, e.wb});
        check("sb_instrout", {16'h0, instrout}, {16'h0, e.instr});
        check("sb_iswb", {31'h0, iswb_out}, {31'h0, e.iswb});
        check("sb_mem_err", {31'h0, mem_err}, {31'h0, e.err});
      end
    end
  end

  task automatic idle_inputs();
    valid_in = 1'b0;
    isld1    = 1'b0;
    isst1    = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] ins, input logic wb);
    valid_in  = 1'b1;
    isld1     = ld;
    isst1     = st;
    aluresult = addr;
    op2_in    = wd;
    instrin   = ins;
    iswb_in   = wb;
    dmem_ack  = 1'b0;
  endtask

  // Issues a memory op at the next edge and serves it; ack_at < 0 means never ack.
  // Returns at the negedge of the cycle where stall falls.
  task automatic mem_op(input logic ld, input logic st, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] ins, input logic wb,
                        input int ack_at, input logic [15:0] rdata,
                        output int n_stall, output int n_req);
    bit done = 0;
    n_stall = 0;
    n_req   = 0;
    @(posedge clk); #1;
    drive(ld, st, addr, wd, ins, wb);
    @(negedge clk);
    check("accept_stall", {31'h0, stall}, 32'h1);
    if (stall) n_stall++;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      dmem_ack   = (i == ack_at);
      dmem_rdata = (i == ack_at) ? rdata : 16'hDEAD;
      @(negedge clk);
      check("req_held", {31'h0, dmem_req}, 32'h1);
      check("addr_held", {16'h0, dmem_addr}, {16'h0, addr});
      check("we_held", {31'h0, dmem_we}, {31'h0, st});
      if (st) check("wdata_held", {16'h0, dmem_wdata}, {16'h0, wd});
      if (dmem_req) n_req++;
      if (stall) n_stall++;
      else done = 1;
    end
    if (!done) check("stall_release_timeout", 32'h0, 32'h1);
  endtask

  int ns, nr;

  initial begin
    // Reset state
    #12;
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_wbdata", {16'h0, wbdata}, 32'h0);
    check("rst_instr", {16'h0, instrout}, 32'h0);
    check("rst_err", {31'h0, mem_err}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ALU passthrough
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd30, 16'h0, 16'hA001, 1'b1);
    exp_q.push_back('{wb: 16'd30, instr: 16'hA001, iswb: 1'b1, err: 1'b0});
    @(negedge clk);
    check("alu_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("alu_valid", {31'h0, valid_out}, 32'h1);
    check("alu_no_req", {31'h0, dmem_req}, 32'h0);
    @(negedge clk);
    check("alu_pulse_end", {31'h0, valid_out}, 32'h0);

    // Load, three waiting cycles then ack
    exp_q.push_back('{wb: 16'hBEEF, instr: 16'hB002, iswb: 1'b1, err: 1'b0});
    mem_op(1'b1, 1'b0, 16'h0040, 16'h5555, 16'hB002, 1'b1, 3, 16'hBEEF, ns, nr);
    check("ld_stall_cycles", ns, 4);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("ld_valid", {31'h0, valid_out}, 32'h1);
    check("ld_req_drop", {31'h0, dmem_req}, 32'h0);

    // Store, ack in first request cycle
    exp_q.push_back('{wb: 16'h0010, instr: 16'hC003, iswb: 1'b0, err: 1'b0});
    mem_op(1'b0, 1'b1, 16'h0010, 16'h1234, 16'hC003, 1'b1, 0, 16'h0, ns, nr);
    check("st_stall_cycles", ns, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("st_valid", {31'h0, valid_out}, 32'h1);

    // Both flags set behaves as a store
    exp_q.push_back('{wb: 16'h0022, instr: 16'hC004, iswb: 1'b0, err: 1'b0});
    mem_op(1'b1, 1'b1, 16'h0022, 16'h4321, 16'hC004, 1'b1, 1, 16'h9999, ns, nr);
    check("ldst_stall_cycles", ns, 2);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);

    // Timeout
    exp_q.push_back('{wb: 16'h0, instr: 16'hD005, iswb: 1'b0, err: 1'b1});
    mem_op(1'b1, 1'b0, 16'h0080, 16'h0, 16'hD005, 1'b1, -1, 16'h0, ns, nr);
    check("to_req_cycles", nr, 15);
    check("to_stall_cycles", ns, 15);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("to_req_drop", {31'h0, dmem_req}, 32'h0);
    check("to_err", {31'h0, mem_err}, 32'h1);
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(negedge clk);
    check("to_err_pulse", {31'h0, mem_err}, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_no_valid", {31'h0, valid_out}, 32'h0);
    check("late_ack_no_req", {31'h0, dmem_req}, 32'h0);

    // Back-to-back: load then ALU op
    exp_q.push_back('{wb: 16'hCAFE, instr: 16'hE006, iswb: 1'b1, err: 1'b0});
    exp_q.push_back('{wb: 16'd7, instr: 16'hE007, iswb: 1'b1, err: 1'b0});
    mem_op(1'b1, 1'b0, 16'h0050, 16'h0, 16'hE006, 1'b1, 1, 16'hCAFE, ns, nr);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd7, 16'h0, 16'hE007, 1'b1);
    @(negedge clk);
    check("b2b_first_valid", {31'h0, valid_out}, 32'h1);
    check("b2b_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("b2b_second_valid", {31'h0, valid_out}, 32'h1);

    // Reset during WAIT
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0060, 16'h0, 16'hF008, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0060, 16'h0, 16'hF008, 1'b1);
    @(negedge clk);
    check("pre_rst_req", {31'h0, dmem_req}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("rst_wait_req", {31'h0, dmem_req}, 32'h0);
    check("rst_wait_valid", {31'h0, valid_out}, 32'h0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back('{wb: 16'd99, instr: 16'h1009, iswb: 1'b1, err: 1'b0});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd99, 16'h0, 16'h1009, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("post_rst_alu_valid", {31'h0, valid_out}, 32'h1);
    @(negedge clk);
    @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline. Sits directly downstream of the `alu` stage and consumes its registered outputs: ALU result, instruction word, load/store flags, store data and write-back flag. It drives a variable-latency data-memory request/acknowledge port and stalls the upstream stage while an access is outstanding. It delivers one registered result per instruction to write-back, with a timeout guard on memory accesses.

## Interface
- `DW`, 16: data and address width.
- `MAX_WAIT`, 15: maximum cycles `dmem_req` may remain high without `dmem_ack` before the access is aborted. Must be at least 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion (0) clears all state immediately; release is synchronised to `clk` upstream.
- `valid_in`  in  1  ALU stage presents a valid instruction.
- `aluresult`  in  DW  ALU result; used as the memory address for loads and stores.
- `instrin`  in  16  instruction word.
- `isld1`  in  1  instruction is a load.
- `isst1`  in  1  instruction is a store.
- `op2_in`  in  DW  store data.
- `iswb_in`  in  1  instruction writes the register file.
- `stall`  out  1  combinational; upstream must hold its outputs while high.
- `dmem_req`  out  1  memory request, registered.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_addr`  out  DW  registered access address.
- `dmem_wdata`  out  DW  registered store data.
- `dmem_rdata`  in  DW  load data; valid in the cycle where `dmem_ack` is high.
- `dmem_ack`  in  1  access complete; may arrive in the first cycle `dmem_req` is high.
- `valid_out`  out  1  write-back bundle valid (one-cycle pulse per instruction).
- `wbdata`  out  DW  load data for loads, otherwise `aluresult`.
- `instrout`  out  16  instruction word, passed through.
- `iswb_out`  out  1  register-file write enable.
- `mem_err`  out  1  one-cycle pulse on access timeout.

## Operation
- States: IDLE, WAIT.
- IDLE, `valid_in`=1, `isld1`=0 and `isst1`=0 (ALU op):
  - Register `wbdata`=`aluresult`, `instrout`, `iswb_out`=`iswb_in`; set `valid_out`=1 next cycle.
  - `stall`=0.
- IDLE, `valid_in`=1, and `isld1` or `isst1` (memory op):
  - `stall`=1.
  - Latch address, write data, `dmem_we`=`isst1`, `instrout`, `iswb_in`.
  - Set `dmem_req`=1 and clear the wait counter; next state WAIT.
- IDLE, `valid_in`=1 with both `isld1` and `isst1` set: treated as a store.
- WAIT:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` held stable.
  - `stall`=1 until `dmem_ack`.
  - On `dmem_ack`:
    - `stall`=0 in the same cycle.
    - Next edge: `dmem_req`=0 and `valid_out`=1.
    - `wbdata`=`dmem_rdata` for a load, or the latched address for a store.
    - Stores force `iswb_out`=0.
    - Next state IDLE.
  - Without ack, the counter increments each cycle. When it reaches `MAX_WAIT`:
    - `stall`=0 in that cycle.
    - Next edge: `dmem_req`=0, `valid_out`=1, `wbdata`=0, `iswb_out`=0, `mem_err`=1; next state IDLE.
  - If ack and timeout coincide, ack wins and `mem_err` stays 0.
- `dmem_ack` while in IDLE is ignored. This covers stale acks after a reset or abort.
- `valid_in`=0 in IDLE: `valid_out`=0 next cycle; other outputs hold.
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `valid_out`, `iswb_out`, `mem_err` = 0; `dmem_addr`, `dmem_wdata`, `wbdata`, `instrout` = 0; counter 0.
- Reset asserted during WAIT: request dropped immediately (asynchronous); no `valid_out` is produced for the aborted instruction.

## Timing
- ALU op: accepted at edge N; `valid_out` high in cycle N+1. Throughput is 1 per cycle.
- Memory op: accepted at edge N; `dmem_req` high from N+1.
  - Ack in cycle N+1+k gives `valid_out` in cycle N+2+k.
  - Minimum load/store latency is 2 cycles.
- The upstream instruction advances on the edge ending the ack or timeout cycle. The following instruction can be accepted in IDLE on the next edge, so there are no bubbles beyond the wait.
- `stall` depends only on state, `valid_in`, the flags, `dmem_ack` and the counter; no other combinational path.

## Structure
- Shared package `proc_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT};
  - `DATA_W`=16 and `INSTR_W`=16.
- Single flat module. The wait counter is `$clog2(MAX_WAIT+1)` bits inline; no sub-module is warranted.

## Test plan
- ALU passthrough: `aluresult`=30, `iswb_in`=1, no ld/st → `valid_out` next cycle, `wbdata`=30, `iswb_out`=1, `stall`=0, `dmem_req` never high.
- Load, ack after 3 cycles with `dmem_rdata`=16'hBEEF, address 16'h0040:
  - `dmem_addr`=16'h0040 and `dmem_we`=0 held for 3 cycles;
  - `stall` high for 4 cycles;
  - `wbdata`=16'hBEEF and `valid_out` 1 cycle after ack.
- Store, same-cycle ack, `op2_in`=16'h1234, address 16'h0010 → `dmem_we`=1, `dmem_wdata`=16'h1234, `valid_out` 2 cycles after acceptance with `iswb_out`=0.
- Timeout, `MAX_WAIT`=15, no ack → `dmem_req` high 15 cycles then drops; `mem_err` pulses once; `wbdata`=0 and `iswb_out`=0; a late ack in IDLE produces no output.
- Back-to-back: load (ack 1 cycle) then ALU op `aluresult`=7 → two `valid_out` pulses in consecutive order; second `wbdata`=7.
- Reset pulled low mid-WAIT → `dmem_req` and `valid_out` drop to 0 immediately; after release, the first ALU op completes with 1-cycle latency.
